// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB master command/response port among N requesters.
// One transaction in flight; the command is latched at grant, and completion is routed back to the winner.
module apb_cmd_arbiter #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned DW = 32,
  parameter  int unsigned AW = 8,
  localparam int unsigned SW = DW / 8,
  localparam int unsigned CW = 1 + SW + DW + AW,
  localparam int unsigned RW = 1 + DW,
  localparam int unsigned GW = $clog2(N)
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [N*CW-1:0] i_req_cmd,
  input  logic [N-1:0]    i_req_valid,
  output logic [RW-1:0]   o_req_resp,
  output logic [N-1:0]    o_req_ready,
  output logic [CW-1:0]   o_m_cmd,
  output logic            o_m_valid,
  input  logic [RW-1:0]   i_m_resp,
  input  logic            i_m_ready,
  output logic            o_busy,
  output logic [GW-1:0]   o_gnt_id
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic            m_valid_q, m_valid_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    req_ready_c;

  logic [CW-1:0]   cmd_arr [N];
  logic [GW-1:0]   scan_idx;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;

  for (genvar g = 0; g < N; g++) begin : g_cmd
    assign cmd_arr[g] = i_req_cmd[g*CW +: CW];
  end

  // First valid requester scanning upward from the one after the last winner.
  always_comb begin
    scan_idx   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      scan_idx = GW'((32'(last_q) + k) % N);
      if (!pick_found && i_req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    m_valid_d   = 1'b0;
    busy_d      = busy_q;
    req_ready_c = '0;
    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          state_d   = ST_ISSUE;
          cmd_d     = cmd_arr[pick_idx];
          gnt_d     = pick_idx;
          m_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is acknowledged in the same cycle the master reports it.
        if (i_m_ready) begin
          req_ready_c[gnt_q] = 1'b1;
          last_d             = gnt_q;
          busy_d             = 1'b0;
          state_d            = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_ARB;
      cmd_q     <= '0;
      gnt_q     <= '0;
      last_q    <= GW'(N - 1);
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_m_cmd     = cmd_q;
  assign o_m_valid   = m_valid_q;
  assign o_busy      = busy_q;
  assign o_gnt_id    = gnt_q;
  assign o_req_ready = req_ready_c;
  assign o_req_resp  = i_m_resp;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter: grant order, latency, latching, wait states and reset abort.
module tb_apb_cmd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 45;
  localparam int unsigned RW = 33;
  localparam int unsigned GW = 2;

  logic            pclk;
  logic            presetn;
  logic [N*CW-1:0] i_req_cmd;
  logic [N-1:0]    i_req_valid;
  logic [RW-1:0]   o_req_resp;
  logic [N-1:0]    o_req_ready;
  logic [CW-1:0]   o_m_cmd;
  logic            o_m_valid;
  logic [RW-1:0]   i_m_resp;
  logic            i_m_ready;
  logic            o_busy;
  logic [GW-1:0]   o_gnt_id;

  logic [CW-1:0]   cmds [N];
  int              errors;
  int              checks;

  assign i_req_cmd = {cmds[3], cmds[2], cmds[1], cmds[0]};

  apb_cmd_arbiter #(.N(N), .DW(32), .AW(8)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_req_cmd   (i_req_cmd),
    .i_req_valid (i_req_valid),
    .o_req_resp  (o_req_resp),
    .o_req_ready (o_req_ready),
    .o_m_cmd     (o_m_cmd),
    .o_m_valid   (o_m_valid),
    .i_m_resp    (i_m_resp),
    .i_m_ready   (i_m_ready),
    .o_busy      (o_busy),
    .o_gnt_id    (o_gnt_id)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [GW-1:0] idx);
    onehot = N'(1) << idx;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    presetn     = 1'b0;
    i_req_valid = '0;
    i_m_ready   = 1'b0;
    i_m_resp    = '0;
    step();
    step();
    presetn = 1'b1;
  endtask

  // Issues one transaction from ARB; 'waits' WAIT cycles pass before the master completes.
  task automatic txn(input string tag, input logic [N-1:0] vmask, input int unsigned waits,
                     input logic [GW-1:0] exp_gnt, input logic [RW-1:0] resp);
    int             cyc;
    logic [CW-1:0]  exp_cmd;
    exp_cmd     = cmds[exp_gnt];
    i_req_valid = vmask;
    cyc = 0;
    while (!o_m_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd1);
    chk({tag, "_valid"}, 64'(o_m_valid), 64'd1);
    chk({tag, "_gnt"}, 64'(o_gnt_id), 64'(exp_gnt));
    chk({tag, "_cmd"}, 64'(o_m_cmd), 64'(exp_cmd));
    chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    step();
    chk({tag, "_vdrop"}, 64'(o_m_valid), 64'd0);
    for (int unsigned w = 1; w < waits; w++) step();
    if (waits > 0) step();
    i_m_ready = 1'b1;
    i_m_resp  = resp;
    #1;
    chk({tag, "_ready"}, 64'(o_req_ready), 64'(onehot(exp_gnt)));
    chk({tag, "_resp"}, 64'(o_req_resp), 64'(resp));
    step();
    i_m_ready   = 1'b0;
    i_req_valid = vmask & ~onehot(exp_gnt);
    #1;
    chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    chk({tag, "_nopulse"}, 64'(o_req_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0] order [6];
    int            n_gnt;
    int            n_rdy;
    logic          prev_v;

    errors  = 0;
    checks  = 0;
    presetn = 1'b0;
    i_req_valid = '0;
    i_m_ready   = 1'b0;
    i_m_resp    = '0;
    for (int k = 0; k < int'(N); k++) cmds[k] = {1'b0, 4'h3, 32'h1000_0000 + 32'(k), 8'(8'h40 + k)};
    #2;
    chk("rst_mvalid", 64'(o_m_valid), 64'd0);
    chk("rst_mcmd", 64'(o_m_cmd), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_gnt", 64'(o_gnt_id), 64'd0);

    // Single requester, ready in cycle 3
    do_reset();
    cmds[0] = {1'b1, 4'hF, 32'hDEADBEEF, 8'h10};
    txn("t1", 4'b0001, 1, 2'd0, 33'h0_12345678);

    // All requesters valid, slave always ready
    do_reset();
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
    order[3] = 2'd3; order[4] = 2'd0; order[5] = 2'd1;
    n_gnt = 0;
    n_rdy = 0;
    prev_v = 1'b0;
    i_req_valid = 4'b1111;
    i_m_ready   = 1'b1;
    i_m_resp    = 33'h1_00000ABC;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (o_m_valid) begin
        chk("t2_order", 64'(o_gnt_id), 64'(order[n_gnt]));
        n_gnt++;
      end
      if (o_req_ready != '0) begin
        chk("t2_onehot", 64'(o_req_ready), 64'(onehot(order[n_rdy])));
        n_rdy++;
      end
      chk("t2_b2b", 64'(o_m_valid && prev_v), 64'd0);
      prev_v = o_m_valid;
      step();
    end
    chk("t2_ngrants", 64'(n_gnt), 64'd5);
    chk("t2_npulses", 64'(n_rdy), 64'd5);
    i_req_valid = '0;
    i_m_ready   = 1'b0;

    // Round-robin pointer after req1 completes
    do_reset();
    txn("t3a", 4'b0010, 1, 2'd1, 33'h0_00000011);
    txn("t3b", 4'b1010, 1, 2'd3, 33'h0_00000033);
    txn("t3c", 4'b0010, 1, 2'd1, 33'h1_00000011);

    // Reset while req2 is in WAIT
    do_reset();
    i_req_valid = 4'b0100;
    step();
    chk("t4_gnt", 64'(o_gnt_id), 64'd2);
    step();
    chk("t4_wait_busy", 64'(o_busy), 64'd1);
    presetn   = 1'b0;
    i_m_ready = 1'b1;
    #1;
    chk("t4_ready", 64'(o_req_ready), 64'd0);
    chk("t4_busy", 64'(o_busy), 64'd0);
    chk("t4_mvalid", 64'(o_m_valid), 64'd0);
    chk("t4_mcmd", 64'(o_m_cmd), 64'd0);
    chk("t4_gid", 64'(o_gnt_id), 64'd0);
    step();
    i_m_ready = 1'b0;
    presetn   = 1'b1;
    txn("t4r", 4'b1111, 1, 2'd0, 33'h0_0000F00D);

    // Master ready while idle in ARB is ignored
    do_reset();
    i_m_ready = 1'b1;
    i_m_resp  = 33'h1_FFFFFFFF;
    #1;
    chk("t5_ready", 64'(o_req_ready), 64'd0);
    step();
    i_m_ready = 1'b0;
    #1;
    chk("t5_busy", 64'(o_busy), 64'd0);
    chk("t5_mvalid", 64'(o_m_valid), 64'd0);
    txn("t5", 4'b0001, 0, 2'd0, 33'h0_00005555);

    // Command change after grant is ignored; five wait states
    do_reset();
    cmds[0] = {1'b1, 4'hF, 32'hCAFE0001, 8'h10};
    i_req_valid = 4'b0001;
    step();
    chk("t6_valid", 64'(o_m_valid), 64'd1);
    chk("t6_cmd", 64'(o_m_cmd), 64'({1'b1, 4'hF, 32'hCAFE0001, 8'h10}));
    cmds[0] = {1'b1, 4'hF, 32'hCAFE0001, 8'h20};
    step();
    for (int w = 0; w < 5; w++) begin
      chk("t6_wbusy", 64'(o_busy), 64'd1);
      chk("t6_waddr", 64'(o_m_cmd[7:0]), 64'h10);
      chk("t6_wready", 64'(o_req_ready), 64'd0);
      step();
    end
    i_m_ready = 1'b1;
    i_m_resp  = 33'h0_0BADF00D;
    #1;
    chk("t6_ready", 64'(o_req_ready), 64'b0001);
    chk("t6_faddr", 64'(o_m_cmd[7:0]), 64'h10);
    step();
    i_m_ready   = 1'b0;
    i_req_valid = '0;
    #1;
    chk("t6_idle", 64'(o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
